// File: rtl/iomem_gpio_pkg.sv
// Register map, warm-up constant and decode helpers shared by the GPIO block.
package iomem_gpio_pkg;

  localparam logic [5:0] OFF_OUT   = 6'h00;
  localparam logic [5:0] OFF_DIR   = 6'h04;
  localparam logic [5:0] OFF_IN    = 6'h08;
  localparam logic [5:0] OFF_SET   = 6'h0C;
  localparam logic [5:0] OFF_CLR   = 6'h10;
  localparam logic [5:0] OFF_TGL   = 6'h14;
  localparam logic [5:0] OFF_IEN   = 6'h18;
  localparam logic [5:0] OFF_IPOL  = 6'h1C;
  localparam logic [5:0] OFF_ISTAT = 6'h20;

  // Cycles after reset release before edges are trusted.
  localparam logic [1:0] PRIME_CNT = 2'd3;

  typedef enum logic [3:0] {
    REG_OUT, REG_DIR, REG_IN, REG_SET, REG_CLR, REG_TGL,
    REG_IEN, REG_IPOL, REG_ISTAT, REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_off(input logic [3:0] word);
    case (word)
      OFF_OUT[5:2]:   return REG_OUT;
      OFF_DIR[5:2]:   return REG_DIR;
      OFF_IN[5:2]:    return REG_IN;
      OFF_SET[5:2]:   return REG_SET;
      OFF_CLR[5:2]:   return REG_CLR;
      OFF_TGL[5:2]:   return REG_TGL;
      OFF_IEN[5:2]:   return REG_IEN;
      OFF_IPOL[5:2]:  return REG_IPOL;
      OFF_ISTAT[5:2]: return REG_ISTAT;
      default:        return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage

// File: rtl/iomem_gpio_if.sv
// picosoc iomem request/response bundle; the CPU side is master, peripherals are slaves.
interface iomem_gpio_if;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/gpio_sync.sv
// Two-flop synchroniser for asynchronous pin inputs, cleared by the synchronous reset.
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk25,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk25) begin
    if (!resetn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/iomem_gpio.sv
// picosoc iomem GPIO block: OUT/DIR/IN plus set/clear/toggle and per-pin edge interrupts.
// One-cycle ack after a hit; registered read data; never stalls beyond that cycle.
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter logic [7:0] BASE_ADDR = 8'h03
) (
  input  logic             clk25,
  input  logic             resetn,
  iomem_gpio_if.slave      bus,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d, ipol_q, ipol_d, istat_q, istat_d;
  logic [WIDTH-1:0] sync_w, dly_q;
  logic [1:0]       prime_q, prime_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             hit;
  reg_sel_e         sel;
  logic [31:0]      strb32;
  logic [WIDTH-1:0] wmask, wbits, stat_clr, rise, fall, edge_hit, rd_sel;
  logic             unused_bits;

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk25 (clk25),
    .resetn(resetn),
    .d_i   (gpio_i),
    .q_o   (sync_w)
  );

  assign hit    = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == BASE_ADDR);
  assign sel    = decode_off(bus.iomem_addr[5:2]);
  assign strb32 = strb_mask(bus.iomem_wstrb);
  assign wmask  = strb32[WIDTH-1:0];
  assign wbits  = bus.iomem_wdata[WIDTH-1:0] & wmask;

  assign rise     = sync_w & ~dly_q;
  assign fall     = ~sync_w & dly_q;
  // Edges are ignored until the synchroniser and delayed copy hold real pin data.
  assign edge_hit = (prime_q == PRIME_CNT) ? (ien_q & ((ipol_q & rise) | (~ipol_q & fall))) : '0;
  assign prime_d  = (prime_q == PRIME_CNT) ? prime_q : prime_q + 2'd1;

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    ien_d    = ien_q;
    ipol_d   = ipol_q;
    stat_clr = '0;
    if (hit) begin
      case (sel)
        REG_OUT:   out_d    = (out_q & ~wmask) | wbits;
        REG_DIR:   dir_d    = (dir_q & ~wmask) | wbits;
        REG_SET:   out_d    = out_q | wbits;
        REG_CLR:   out_d    = out_q & ~wbits;
        REG_TGL:   out_d    = out_q ^ wbits;
        REG_IEN:   ien_d    = (ien_q & ~wmask) | wbits;
        REG_IPOL:  ipol_d   = (ipol_q & ~wmask) | wbits;
        REG_ISTAT: stat_clr = wbits;
        default:   ;
      endcase
    end
    // A new edge wins over a simultaneous clear of the same bit.
    istat_d = (istat_q & ~stat_clr) | edge_hit;
  end

  always_comb begin
    rd_sel = '0;
    case (sel)
      REG_OUT:   rd_sel = out_q;
      REG_DIR:   rd_sel = dir_q;
      REG_IN:    rd_sel = sync_w;
      REG_IEN:   rd_sel = ien_q;
      REG_IPOL:  rd_sel = ipol_q;
      REG_ISTAT: rd_sel = istat_q;
      default:   rd_sel = '0;
    endcase
    rdata_d = '0;
    if (hit) rdata_d[WIDTH-1:0] = rd_sel;
    ready_d = hit;
  end

  always_ff @(posedge clk25) begin
    if (!resetn) begin
      out_q   <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      ipol_q  <= '0;
      istat_q <= '0;
      dly_q   <= '0;
      prime_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      ipol_q  <= ipol_d;
      istat_q <= istat_d;
      dly_q   <= sync_w;
      prime_q <= prime_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign gpio_o          = out_q;
  assign gpio_oe         = dir_q;
  assign irq             = |(istat_q & ien_q);

  assign unused_bits = ^{bus.iomem_addr[23:6], bus.iomem_addr[1:0], bus.iomem_wdata, strb32};

endmodule

// File: tb/tb_iomem_gpio.sv
// Randomised register/pin traffic against a behavioural register-map model, plus directed corner cases.
module tb_iomem_gpio;
  import iomem_gpio_pkg::*;

  localparam int W = 8;
  localparam logic [5:0] RD_OFFS [8]  = '{6'h00, 6'h04, 6'h08, 6'h18, 6'h1C, 6'h20, 6'h24, 6'h3C};
  localparam logic [5:0] WR_OFFS [11] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14,
                                         6'h18, 6'h1C, 6'h20, 6'h24, 6'h3C};

  logic         clk25 = 1'b0;
  logic         resetn;
  logic [W-1:0] gpio_i, gpio_o, gpio_oe;
  logic         irq;

  iomem_gpio_if bus ();

  iomem_gpio #(.WIDTH(W), .BASE_ADDR(8'h03)) dut (
    .clk25  (clk25),
    .resetn (resetn),
    .bus    (bus),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .gpio_oe(gpio_oe),
    .irq    (irq)
  );

  always #20 clk25 = ~clk25;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural view of the block.
  logic [W-1:0] m_out, m_dir, m_ien, m_ipol, m_istat, m_pins;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  function automatic void model_write(input logic [5:0] off, input logic [31:0] wd, input logic [3:0] st);
    logic [W-1:0] b;
    b = st[0] ? wd[W-1:0] : '0;
    case (off)
      6'h00: m_out   = st[0] ? wd[W-1:0] : m_out;
      6'h04: m_dir   = st[0] ? wd[W-1:0] : m_dir;
      6'h0C: m_out   = m_out | b;
      6'h10: m_out   = m_out & ~b;
      6'h14: m_out   = m_out ^ b;
      6'h18: m_ien   = st[0] ? wd[W-1:0] : m_ien;
      6'h1C: m_ipol  = st[0] ? wd[W-1:0] : m_ipol;
      6'h20: m_istat = m_istat & ~b;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] off);
    case (off)
      6'h00:   return 32'(m_out);
      6'h04:   return 32'(m_dir);
      6'h08:   return 32'(m_pins);
      6'h18:   return 32'(m_ien);
      6'h1C:   return 32'(m_ipol);
      6'h20:   return 32'(m_istat);
      default: return 32'h0;
    endcase
  endfunction

  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output bit acked);
    bus.iomem_addr  = addr;
    bus.iomem_wdata = wdata;
    bus.iomem_wstrb = wstrb;
    bus.iomem_valid = 1'b1;
    acked = 1'b0;
    rdata = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      tick(1);
      if (bus.iomem_ready) begin
        acked = 1'b1;
        rdata = bus.iomem_rdata;
      end
    end
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
  endtask

  task automatic reg_wr(input string tag, input logic [5:0] off, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] rd;
    bit          ack;
    bus_xfer({8'h03, 18'($urandom()), off}, wd, st, rd, ack);
    check_eq({tag, "_ack"}, 32'(ack), 32'd1);
    model_write(off, wd, st);
  endtask

  task automatic reg_rd(input string tag, input logic [5:0] off);
    logic [31:0] rd;
    bit          ack;
    bus_xfer({8'h03, 18'($urandom()), off}, 32'($urandom()), 4'h0, rd, ack);
    check_eq({tag, "_ack"}, 32'(ack), 32'd1);
    check_eq(tag, rd, model_read(off));
  endtask

  task automatic set_pins(input logic [W-1:0] nv);
    logic [W-1:0] rise, fall;
    rise   = nv & ~m_pins;
    fall   = ~nv & m_pins;
    gpio_i = nv;
    tick(5);
    m_istat = m_istat | (m_ien & ((m_ipol & rise) | (~m_ipol & fall)));
    m_pins  = nv;
  endtask

  task automatic check_pins_out(input string tag);
    check_eq({tag, "_gpio_o"}, 32'(gpio_o), 32'(m_out));
    check_eq({tag, "_gpio_oe"}, 32'(gpio_oe), 32'(m_dir));
    check_eq({tag, "_irq"}, 32'(irq), 32'(|(m_istat & m_ien)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          ack;
    int          r;

    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_addr  = '0;
    bus.iomem_wdata = '0;
    gpio_i = 8'hFF;
    resetn = 1'b0;
    tick(3);
    check_eq("rst_ready", 32'(bus.iomem_ready), 32'd0);
    check_eq("rst_rdata", bus.iomem_rdata, 32'd0);
    check_eq("rst_gpio_o", 32'(gpio_o), 32'd0);
    check_eq("rst_gpio_oe", 32'(gpio_oe), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);

    // Access issued in the same cycle reset is reasserted must never be acknowledged.
    resetn = 1'b1;
    tick(1);
    bus.iomem_addr  = 32'h0300_0000;
    bus.iomem_valid = 1'b1;
    resetn = 1'b0;
    tick(1);
    check_eq("inflight_ready", 32'(bus.iomem_ready), 32'd0);
    bus.iomem_valid = 1'b0;
    tick(1);
    check_eq("inflight_ready2", 32'(bus.iomem_ready), 32'd0);
    tick(1);
    resetn = 1'b1;

    m_out = '0; m_dir = '0; m_ien = '0; m_ipol = '0; m_istat = '0; m_pins = 8'hFF;

    // Pins high through reset must not look like rising edges.
    reg_wr("en_all", OFF_IEN, 32'hFF, 4'h1);
    reg_wr("pol_all", OFF_IPOL, 32'hFF, 4'h1);
    tick(4);
    reg_rd("no_spurious_stat", OFF_ISTAT);
    check_eq("no_spurious_irq", 32'(irq), 32'd0);

    reg_wr("out_a5", OFF_OUT, 32'hA5, 4'b0001);
    check_eq("out_a5_pins", 32'(gpio_o), 32'hA5);
    reg_wr("out_nostrb", OFF_OUT, 32'h00, 4'b0000);
    check_eq("out_nostrb_pins", 32'(gpio_o), 32'hA5);
    reg_wr("out_hibytes", OFF_OUT, 32'hFFFF_FF00, 4'b1110);
    check_eq("out_hibytes_pins", 32'(gpio_o), 32'hA5);

    reg_wr("out_f0", OFF_OUT, 32'hF0, 4'hF);
    reg_wr("set_03", OFF_SET, 32'h03, 4'hF);
    reg_wr("clr_10", OFF_CLR, 32'h10, 4'hF);
    reg_wr("tgl_81", OFF_TGL, 32'h81, 4'hF);
    bus_xfer(32'h0300_0000, 32'h0, 4'h0, rd, ack);
    check_eq("out_62", rd, 32'h62);
    reg_wr("dir_3c", OFF_DIR, 32'h0000_013C, 4'b0011);
    check_pins_out("dir_3c");
    reg_rd("in_ff", OFF_IN);
    reg_wr("in_write", OFF_IN, 32'h00, 4'hF);
    reg_rd("in_after_write", OFF_IN);

    // Single rising edge on pin 0: pending in exactly three cycles.
    reg_wr("en_off", OFF_IEN, 32'h00, 4'h1);
    set_pins(8'h00);
    reg_wr("en_01", OFF_IEN, 32'h01, 4'h1);
    reg_wr("pol_01", OFF_IPOL, 32'h01, 4'h1);
    gpio_i = 8'h01;
    tick(2);
    check_eq("irq_early", 32'(irq), 32'd0);
    tick(1);
    check_eq("irq_rise", 32'(irq), 32'd1);
    m_pins = 8'h01;
    m_istat = 8'h01;
    reg_rd("stat_01", OFF_ISTAT);
    reg_wr("w1c_01", OFF_ISTAT, 32'h01, 4'h1);
    check_eq("irq_cleared", 32'(irq), 32'd0);

    // Falling edge on pin 2 meeting a W1C of the same bit.
    reg_wr("en_05", OFF_IEN, 32'h05, 4'h1);
    set_pins(8'h05);
    gpio_i = 8'h01;
    tick(2);
    bus.iomem_addr  = 32'h0300_0020;
    bus.iomem_wdata = 32'h04;
    bus.iomem_wstrb = 4'h1;
    bus.iomem_valid = 1'b1;
    tick(1);
    check_eq("coincide_ack", 32'(bus.iomem_ready), 32'd1);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    m_pins  = 8'h01;
    m_istat = 8'h04;
    reg_rd("coincide_stat", OFF_ISTAT);
    check_eq("coincide_irq", 32'(irq), 32'd1);
    reg_wr("w1c_04", OFF_ISTAT, 32'h04, 4'h1);
    reg_rd("stat_clean", OFF_ISTAT);

    bus_xfer(32'h0300_003C, 32'h0, 4'h0, rd, ack);
    check_eq("unmapped_ack", 32'(ack), 32'd1);
    check_eq("unmapped_rdata", rd, 32'd0);
    bus_xfer(32'h0200_0000, 32'h0, 4'h0, rd, ack);
    check_eq("foreign_base_ack", 32'(ack), 32'd0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        set_pins(8'($urandom()));
      end else if (r < 6) begin
        reg_wr("rnd_wr", WR_OFFS[$urandom_range(0, 10)], $urandom(), 4'($urandom()));
      end else begin
        reg_rd("rnd_rd", RD_OFFS[$urandom_range(0, 7)]);
      end
      check_pins_out("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iomem_gpio.md
IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning GPIO pin count, legal range 1..32.
REQ-002 SHALL have parameter BASE_ADDR, default 8'h03, meaning the value iomem_addr[31:24] must match to select the block.
REQ-003 SHALL have port clk25, input, 1, system clock.
REQ-004 SHALL have port resetn, input, 1, reset, synchronous, active-low; clock is clk25.
REQ-005 SHALL have ports iomem_valid (input, 1), iomem_wstrb (input, 4), iomem_addr (input, 32) and iomem_wdata (input, 32), forming the picosoc iomem request.
REQ-006 SHALL have port iomem_ready, output, 1, one-cycle accept pulse.
REQ-007 SHALL have port iomem_rdata, output, 32, read data qualified by iomem_ready.
REQ-008 SHALL have port gpio_i, input, WIDTH, asynchronous pin inputs.
REQ-009 SHALL have ports gpio_o (output, WIDTH, pin output values) and gpio_oe (output, WIDTH, per-pin output enable, 1 = drive).
REQ-010 SHALL have port irq, output, 1, level interrupt.

Function
REQ-011 SHALL decode a hit as iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_ADDR.
REQ-012 SHALL pulse iomem_ready high for exactly one cycle, in the cycle after a hit, and SHALL NOT re-accept while iomem_ready is high.
REQ-013 SHALL register iomem_rdata in the same edge that raises iomem_ready, and SHALL return 0 for bits at or above WIDTH and for unmapped offsets.
REQ-014 SHALL apply writes only to bytes whose iomem_wstrb bit is set; read side effects are none.
REQ-015 SHALL use this register map (offset = iomem_addr[5:0], word aligned):
- 0x00 OUT: RW, drives gpio_o.
- 0x04 DIR: RW, drives gpio_oe.
- 0x08 IN: RO, synchronised pins.
- 0x0C SET: W1S into OUT.
- 0x10 CLR: W1C into OUT.
- 0x14 TGL: W1-toggle into OUT.
- 0x18 IRQ_EN: RW.
- 0x1C IRQ_POL: RW, 1 = rising, 0 = falling.
- 0x20 IRQ_STAT: R, W1C.
REQ-016 SHALL ignore writes to IN, to unmapped offsets, and to bits at or above WIDTH, while still acknowledging them.
REQ-017 SHALL pass gpio_i through a two-flop synchroniser; IN SHALL reflect a pin change 2 cycles after the sampling edge.
REQ-018 SHALL detect edges by comparing the synchronised value with its one-cycle-delayed copy, and SHALL set IRQ_STAT[n] when IRQ_EN[n]=1 and the edge matches IRQ_POL[n], the edge being visible 3 cycles after the pin change.
REQ-019 SHALL give set priority when an edge and a W1C clear of the same bit coincide, so the bit remains 1.
REQ-020 SHALL NOT clear pending IRQ_STAT bits when IRQ_EN is cleared; irq SHALL equal |(IRQ_STAT & IRQ_EN), combinational from registers.
REQ-021 SHALL suppress edge detection for the first 3 cycles after resetn deasserts, using a 2-bit prime counter, so that pins high at reset raise no spurious IRQ.
REQ-022 SHALL make gpio_o follow OUT regardless of DIR, and SHALL make the IN readback reflect the pin even for output pins.

Reset
REQ-023 SHALL reset OUT, DIR, IRQ_EN, IRQ_POL, IRQ_STAT, synchroniser flops, delayed copy and prime counter to 0.
REQ-024 SHALL hold iomem_ready=0, iomem_rdata=0, gpio_o=0, gpio_oe=0 and irq=0 during reset.
REQ-025 SHALL drop an access in flight when resetn asserts, with no iomem_ready pulse afterwards.

Structure
REQ-026 SHALL place register offset localparams and the prime count constant in package iomem_gpio_pkg.
REQ-027 SHALL implement the synchroniser as sub-module gpio_sync, parametrised by WIDTH, with 2 stages and reset.

Verification
REQ-028 SHALL cover, with WIDTH=8: write OUT=0xA5 with wstrb=4'b0001 -> gpio_o=0xA5 next cycle; then wstrb=0 -> unchanged.
REQ-029 SHALL cover: OUT=0xF0, then SET 0x03, CLR 0x10, TGL 0x81 -> OUT reads 0x62.
REQ-030 SHALL cover: IRQ_EN=0x01, POL=0x01, gpio_i[0] 0->1 -> IRQ_STAT=0x01 and irq=1 within 3 cycles; W1C 0x01 -> irq=0.
REQ-031 SHALL cover: a falling edge on bit 2 with POL[2]=0 coinciding with a W1C of bit 2 -> IRQ_STAT[2] remains 1.
REQ-032 SHALL cover: gpio_i=0xFF held through reset, all IRQ_EN=0xFF, POL=0xFF -> no IRQ_STAT bit set after release.
REQ-033 SHALL cover: read offset 0x3C and an access with addr[31:24]=0x02 -> first acked with rdata=0, second never acked.
